// File: rtl/host_wg_rx.sv
// host_wg_rx: accepts workgroup descriptors from the host over a level
// valid / one-cycle ack handshake and queues them in a small FIFO for the
// downstream dispatcher.
//
// Host side: host_wg_valid is a level held until inflight_wg_buffer_host_rcvd_ack
// pulses. A descriptor is accepted on the edge where the FSM is in RX_IDLE,
// valid is high and the FIFO is not full. The ack follows one cycle later.
// Valid must then be seen low once before the next descriptor is taken.
// Downstream side: a descriptor moves on every edge where rx_wg_valid and
// rx_wg_ready are both high.
//
// Optional feature: define HOST_WG_RX_CHECK_EN to build the descriptor
// consistency checker that drives the sticky rx_desc_err flag.
module host_wg_rx #(
  parameter int WG_ID_WIDTH     = 6,
  parameter int WF_COUNT_WIDTH  = 4,
  parameter int WAVE_ITEM_WIDTH = 6,
  parameter int VGPR_ID_WIDTH   = 8,
  parameter int SGPR_ID_WIDTH   = 4,
  parameter int LDS_ID_WIDTH    = 8,
  parameter int GDS_ID_WIDTH    = 14,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int RX_FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               host_wg_valid,
  input  logic [WG_ID_WIDTH-1:0]             host_wg_id,
  input  logic [WF_COUNT_WIDTH-1:0]          host_num_wf,
  input  logic [WAVE_ITEM_WIDTH-1:0]         host_wf_size,
  input  logic [VGPR_ID_WIDTH:0]             host_vgpr_size_per_wf,
  input  logic [VGPR_ID_WIDTH:0]             host_vgpr_size_total,
  input  logic [SGPR_ID_WIDTH:0]             host_sgpr_size_per_wf,
  input  logic [SGPR_ID_WIDTH:0]             host_sgpr_size_total,
  input  logic [LDS_ID_WIDTH:0]              host_lds_size_total,
  input  logic [GDS_ID_WIDTH:0]              host_gds_size_total,
  input  logic [MEM_ADDR_WIDTH-1:0]          host_start_pc,
  output logic                               inflight_wg_buffer_host_rcvd_ack,
  output logic                               rx_wg_valid,
  input  logic                               rx_wg_ready,
  output logic [WG_ID_WIDTH-1:0]             rx_wg_id,
  output logic [WF_COUNT_WIDTH-1:0]          rx_wg_num_wf,
  output logic [WAVE_ITEM_WIDTH-1:0]         rx_wg_wf_size,
  output logic [VGPR_ID_WIDTH:0]             rx_wg_vgpr_size_per_wf,
  output logic [VGPR_ID_WIDTH:0]             rx_wg_vgpr_size_total,
  output logic [SGPR_ID_WIDTH:0]             rx_wg_sgpr_size_per_wf,
  output logic [SGPR_ID_WIDTH:0]             rx_wg_sgpr_size_total,
  output logic [LDS_ID_WIDTH:0]              rx_wg_lds_size_total,
  output logic [GDS_ID_WIDTH:0]              rx_wg_gds_size_total,
  output logic [MEM_ADDR_WIDTH-1:0]          rx_wg_start_pc,
  output logic [$clog2(RX_FIFO_DEPTH):0]     rx_fifo_count,
  output logic                               rx_fifo_full,
  output logic                               rx_desc_err,
  output logic [1:0]                         rx_state
);

  localparam int PTR_W  = $clog2(RX_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DESC_W = WG_ID_WIDTH + WF_COUNT_WIDTH + WAVE_ITEM_WIDTH
                        + 2 * (VGPR_ID_WIDTH + 1) + 2 * (SGPR_ID_WIDTH + 1)
                        + (LDS_ID_WIDTH + 1) + (GDS_ID_WIDTH + 1) + MEM_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RX_FIFO_DEPTH);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_ACK   = 2'd1;
  localparam logic [1:0] RX_REARM = 2'd2;

  logic [1:0]        state;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DESC_W-1:0] mem [RX_FIFO_DEPTH];
  logic [DESC_W-1:0] wr_desc;
  logic              push;
  logic              pop;

  // Full uses the registered count, so a pop this cycle never frees room
  // for a push in the same cycle.
  assign rx_fifo_full = (rx_fifo_count == DEPTH_C);
  assign rx_wg_valid  = (rx_fifo_count != '0);
  assign push         = (state == RX_IDLE) && host_wg_valid && !rx_fifo_full;
  assign pop          = rx_wg_valid && rx_wg_ready;
  assign rx_state     = state;

  assign wr_desc = {host_wg_id, host_num_wf, host_wf_size,
                    host_vgpr_size_per_wf, host_vgpr_size_total,
                    host_sgpr_size_per_wf, host_sgpr_size_total,
                    host_lds_size_total, host_gds_size_total, host_start_pc};

  assign {rx_wg_id, rx_wg_num_wf, rx_wg_wf_size,
          rx_wg_vgpr_size_per_wf, rx_wg_vgpr_size_total,
          rx_wg_sgpr_size_per_wf, rx_wg_sgpr_size_total,
          rx_wg_lds_size_total, rx_wg_gds_size_total, rx_wg_start_pc} = mem[rd_ptr];

  // Handshake FSM; reset lands in RX_REARM so a valid held through reset
  // must drop once before anything is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state                            <= RX_REARM;
      inflight_wg_buffer_host_rcvd_ack <= 1'b0;
    end else begin
      inflight_wg_buffer_host_rcvd_ack <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (push) begin
            state                            <= RX_ACK;
            inflight_wg_buffer_host_rcvd_ack <= 1'b1;
          end
        end
        RX_ACK:   state <= RX_REARM;
        RX_REARM: if (!host_wg_valid) state <= RX_IDLE;
        default:  state <= RX_REARM;
      endcase
    end
  end

  // FIFO pointers and occupancy; push+pop together leaves the count alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rx_fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      rx_fifo_count <= rx_fifo_count + 1'b1;
      else if (pop && !push) rx_fifo_count <= rx_fifo_count - 1'b1;
    end
  end

  // Descriptor storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_desc;
  end

`ifdef HOST_WG_RX_CHECK_EN
  localparam int VP_W = VGPR_ID_WIDTH + 1 + WF_COUNT_WIDTH;
  localparam int SP_W = SGPR_ID_WIDTH + 1 + WF_COUNT_WIDTH;

  logic [VP_W-1:0] vgpr_prod;
  logic [SP_W-1:0] sgpr_prod;
  logic            desc_bad;

  assign vgpr_prod = VP_W'(host_vgpr_size_per_wf) * VP_W'(host_num_wf);
  assign sgpr_prod = SP_W'(host_sgpr_size_per_wf) * SP_W'(host_num_wf);
  assign desc_bad  = (host_num_wf == '0)
                   || (VP_W'(host_vgpr_size_total) != vgpr_prod)
                   || (SP_W'(host_sgpr_size_total) != sgpr_prod);

  // Sticky error: set on the accept edge of an inconsistent descriptor.
  always_ff @(posedge clk) begin
    if (!rst)                 rx_desc_err <= 1'b0;
    else if (push && desc_bad) rx_desc_err <= 1'b1;
  end
`else
  assign rx_desc_err = 1'b0;
`endif

endmodule

// File: doc/host_wg_rx.md
HOST_WG_RX -- requirements
Module: host_wg_rx

Interface
REQ-001 SHALL have parameters (name, default, meaning):
  - WG_ID_WIDTH, 6, workgroup id bits
  - WF_COUNT_WIDTH, 4, wavefront count bits
  - WAVE_ITEM_WIDTH, 6, wf_size bits
  - VGPR_ID_WIDTH, 8; SGPR_ID_WIDTH, 4; LDS_ID_WIDTH, 8; GDS_ID_WIDTH, 14: resource id bits; size fields are id width + 1
  - MEM_ADDR_WIDTH, 32, start PC bits
  - RX_FIFO_DEPTH, 4, descriptor FIFO entries, power of 2
REQ-002 SHALL have ports (name, direction, width, meaning):
  - clk, in, 1, sole clock
  - rst, in, 1, synchronous active-low reset
  - host_wg_valid, in, 1, host descriptor valid (level, held until acked)
  - host_wg_id, host_num_wf, host_wf_size, host_vgpr_size_per_wf, host_vgpr_size_total, host_sgpr_size_per_wf, host_sgpr_size_total, host_lds_size_total, host_gds_size_total, host_start_pc: in, per REQ-001, descriptor fields
  - inflight_wg_buffer_host_rcvd_ack, out, 1, one-cycle accept pulse to host
  - rx_wg_valid, out, 1, FIFO head valid
  - rx_wg_ready, in, 1, downstream pop request
  - rx_wg_* (the same ten fields), out, per REQ-001, FIFO head descriptor
  - rx_fifo_count, out, log2(RX_FIFO_DEPTH)+1, occupancy
  - rx_fifo_full, out, 1, count == RX_FIFO_DEPTH
  - rx_desc_err, out, 1, sticky descriptor-check error (REQ-019)

Function
REQ-003 SHALL run an FSM with states RX_IDLE, RX_ACK and RX_REARM.
REQ-004 In RX_IDLE, with host_wg_valid=1 and rx_fifo_full=0, SHALL push all ten fields into the FIFO on that edge and go to RX_ACK.
REQ-005 In RX_IDLE, with host_wg_valid=1 and rx_fifo_full=1, SHALL stay in RX_IDLE, push nothing and keep ack low (backpressure).
REQ-006 In RX_ACK, SHALL drive inflight_wg_buffer_host_rcvd_ack=1 for exactly that cycle, then go to RX_REARM; ack SHALL be registered and low in every other state.
REQ-007 In RX_REARM, SHALL ignore host_wg_valid=1 and go to RX_IDLE only after sampling host_wg_valid=0. A valid the host holds after the ack is never accepted twice.
REQ-008 Accept-to-ack latency SHALL be 1 cycle; the minimum host-visible cycle per WG SHALL be 3 edges (IDLE, ACK, REARM plus one low sample).
REQ-009 rx_wg_valid SHALL equal (rx_fifo_count != 0); rx_wg_* SHALL present the head entry combinationally from storage.
REQ-010 A pop SHALL occur when rx_wg_valid && rx_wg_ready; rx_wg_ready with the FIFO empty SHALL have no effect.
REQ-011 The full check in REQ-004/005 SHALL use the registered count; a pop in the same cycle SHALL NOT unblock a push in that cycle.
REQ-012 A push and a pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-013 Pointers SHALL be log2(RX_FIFO_DEPTH) bits and wrap modulo depth; count SHALL never exceed RX_FIFO_DEPTH or underflow.
REQ-014 Output order SHALL equal acceptance order; field values SHALL pass bit-exact with no arithmetic applied.

Reset
REQ-015 With rst=0 at a clk edge: FSM to RX_REARM, pointers and count to 0, FIFO contents discarded.
REQ-016 Reset values SHALL be: ack=0, rx_wg_valid=0, rx_fifo_full=0, rx_fifo_count=0, rx_desc_err=0. rx_wg_* values are don't-care while rx_wg_valid=0.
REQ-017 Reset mid-handshake SHALL drop any un-acked descriptor. After reset, a valid still held SHALL NOT be accepted until it has been seen low once.

Configuration
REQ-018 Macro HOST_WG_RX_CHECK_EN SHALL select descriptor checking.
REQ-019 With HOST_WG_RX_CHECK_EN defined, each accepted descriptor SHALL be checked. rx_desc_err SHALL set one cycle after acceptance and stay set until reset if any of these hold:
  - num_wf == 0
  - vgpr_size_total != vgpr_size_per_wf*num_wf (full-width product)
  - sgpr_size_total != sgpr_size_per_wf*num_wf
  Such descriptors SHALL still be pushed and acked.
REQ-020 With the macro undefined, rx_desc_err SHALL be tied 0 and no check logic SHALL be built.

Verification
REQ-021 Single WG: valid=1, wg_id=3, num_wf=2, vgpr 10/20 -> ack pulses 1 cycle, one cycle after the accept edge; rx_wg_valid=1, rx_wg_id=3, count=1.
REQ-022 Host holds valid 2 cycles after ack -> exactly 1 push (count=1); the next WG is accepted only after valid is low for 1 cycle.
REQ-023 5 WGs (ids 0-4) with rx_wg_ready=0 -> ids 0-3 acked, full=1, id 4 stalls unacked; one pop -> id 4 acked next cycle; pops yield 0,1,2,3,4 in order.
REQ-024 count=2 with push and pop in the same cycle -> count stays 2, head advances; depth-wrap across 6 WGs keeps order.
REQ-025 rst=0 during RX_ACK with count=3 -> count=0, ack=0, rx_wg_valid=0; held valid is not re-accepted until it toggles low.
REQ-026 CHECK_EN defined: num_wf=3, vgpr_per_wf=5, vgpr_total=14 -> ack still given, rx_desc_err=1 and sticky. Macro undefined: same stimulus -> rx_desc_err=0.
